tanh_bf16_arbiter: RTL and testbench
====================================

Name: tanh_bf16_arbiter

Overview:
Shares one bfloat16 tanh LUT pipeline (4 enabled cycles, global enable) between NUM_REQ requesters. Each requester has a valid/ready port. The block grants one request per cycle with round-robin priority and drives the core's input and enable. It tracks valid and requester tag alongside the core's fixed latency, and presents tagged results on one valid/ready output port. Whole-pipeline stall under output backpressure is done through the core enable.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
TAG_W, 2, tag width; must equal clog2(NUM_REQ)
CORE_LAT, 4, enabled-cycle latency of the tanh core, input sample to registered output

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  16*NUM_REQ  per-requester bf16 operand; requester i uses bits [16i+15:16i]
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
core_din  out  16  operand to the tanh core input
core_en  out  1  tanh core enable
core_dout  in  16  tanh core registered result
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  16  bf16 tanh result (core_dout passthrough)
out_tag  out  TAG_W  index of the originating requester
in_flight  out  clog2(CORE_LAT+1)  number of valid entries in the pipeline
busy  out  1  in_flight != 0

Behaviour:
- Reset (async, asynchronously asserted):
  - valid shift register, tag shift register, rr_ptr and in_flight all cleared.
  - Outputs: out_valid=0, out_tag=0, req_ready=0, in_flight=0, busy=0; core_en=1.
  - The core itself has no reset. Stale core contents are masked because all valid bits are 0.
- Stall rule: stall = out_valid & ~out_ready; core_en = ~stall (combinational).
  - During stall, the core, the valid/tag shift registers and rr_ptr all hold.
  - out_data and out_tag stay stable until accepted.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins.
  - grant = one-hot of the winner. req_ready = grant when ~stall, else 0.
  - Issue = |grant & ~stall.
- core_din = req_data of the granted requester on issue, else 16'h0000 (don't-care, masked by valid).
- On issue:
  - Stage-0 valid=1 and stage-0 tag=winner index enter the shift registers.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - With no issue and ~stall, stage-0 valid=0 and rr_ptr holds.
- Shift registers: depth CORE_LAT, advance exactly on core_en. out_valid = last valid stage; out_tag = last tag stage.
  - A request issued at enabled edge k appears at out_valid after edge k+CORE_LAT-1 (CORE_LAT enabled cycles including the issue edge).
  - With no stalls, the result is visible 4 cycles after the handshake cycle.
- Throughput: 1 issue/cycle when out_ready=1. Output is accepted on out_valid & out_ready.
- in_flight:
  - Registered count of set valid stages.
  - Updated each enabled edge as +issue − (out_valid & out_ready).
  - Never exceeds CORE_LAT.
- Requester protocol: req_data must stay stable while req_valid=1 and ready=0. The block does not require valid to stay high, and tolerates withdrawal.
- Boundary conditions:
  - All requesters valid every cycle: each is granted once per NUM_REQ cycles.
  - A single requester is granted every cycle.
  - If out_ready drops while out_valid=0, there is no stall; the pipeline keeps filling until a valid reaches the output.
  - Reset asserted mid-operation drops all in-flight results; no out_valid until new issues complete.

Decomposition:
- Package tanh_bf16_pkg:
  - BF16_W=16, BF16_ONE=16'h3F80, TANH_CORE_LAT=4.
  - tag_t typedef sized from NUM_REQ.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ req vector, rr_ptr.
  - Outputs: one-hot grant, binary index, any_grant.
  - Purely combinational; pointer register stays in the parent.
- The tanh core is instantiated by the integrator next to this block, not inside it.

Test Plan:
1. Reset, then only requester 2 issues 16'h3F80 once with out_ready=1 → req_ready[2]=1 that cycle; out_valid=1, out_tag=2, out_data=core_dout exactly CORE_LAT cycles later; in_flight back to 0.
2. All four req_valid held high for 8 cycles, rr_ptr=0 after reset → grant order 0,1,2,3,0,1,2,3; outputs in the same tag order, one per cycle.
3. Fill the pipe, then drop out_ready for 5 cycles → core_en=0, req_ready=0, and out_data/out_tag frozen for all 5 cycles; after release, the remaining results drain in order with no loss or duplication.
4. Assert rst with in_flight=3 → out_valid=0 and in_flight=0 immediately (async); the next single request's result appears CORE_LAT cycles after its issue.
5. Requesters 1 and 3 valid, 3 drops valid after one grant to 1 → second grant goes to 3 only if still valid, else 1 again; no grant to an invalid requester.
6. Random valid/ready traffic for 10k cycles against a reference queue model → every accepted request returns exactly once with the correct tag. in_flight matches the model every cycle and never exceeds 4.

Source files
------------

// File: rtl/tanh_bf16_arbiter_pkg.sv
// Shared constants and types for the bf16 tanh arbiter slice.
package tanh_bf16_pkg;
    localparam int BF16_W = 16;
    localparam logic [15:0] BF16_ONE = 16'h3F80;
    localparam int TANH_CORE_LAT = 4;
    localparam int NUM_REQ_DEF = 4;
    localparam int TAG_W_DEF = $clog2(NUM_REQ_DEF);

    typedef logic [TAG_W_DEF-1:0] tag_t;

    typedef struct packed {
        tag_t        tag;
        logic [15:0] data;
    } tagged_result_t;
endpackage

// File: rtl/tanh_bf16_arbiter_if.sv
// Requester and result handshake bundle; slave side belongs to the arbiter.
interface tanh_bf16_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_data;
    logic [TAG_W-1:0]      out_tag;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_tag
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/tanh_bf16_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   win_idx,
    output logic               any_grant
);

    // Scan requests from the pointer position, wrapping modulo NUM_REQ
    always_comb begin
        int j;
        grant     = '0;
        win_idx   = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!any_grant && req[j]) begin
                any_grant = 1'b1;
                grant[j]  = 1'b1;
                win_idx   = TAG_W'(j);
            end else begin
                any_grant = any_grant;
            end
        end
    end

endmodule

// File: rtl/tanh_bf16_arbiter.sv
// Round-robin sharing of one fixed-latency bf16 tanh core; valid and tag ride
// a shift register matched to the core latency, stalled through the core enable.
module tanh_bf16_arbiter
    import tanh_bf16_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int CORE_LAT = TANH_CORE_LAT,
    localparam int IF_W    = $clog2(CORE_LAT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    tanh_bf16_arbiter_if.slave bus,
    output logic [15:0]        core_din,
    output logic               core_en,
    input  logic [15:0]        core_dout,
    output logic [IF_W-1:0]    in_flight,
    output logic               busy
);

    logic [CORE_LAT-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [CORE_LAT];
    logic [TAG_W-1:0]    tag_d [CORE_LAT];
    logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IF_W-1:0]     in_flight_q, in_flight_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic [TAG_W-1:0]    win_idx_s;
    logic                any_grant_s;
    logic                stall_s;
    logic                issue_s;
    logic                accept_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant_s),
        .win_idx   (win_idx_s),
        .any_grant (any_grant_s)
    );

    // A valid result waiting on downstream freezes the whole pipeline
    always_comb begin
        stall_s  = valid_q[CORE_LAT-1] & ~bus.out_ready;
        accept_s = valid_q[CORE_LAT-1] & bus.out_ready;
        issue_s  = any_grant_s & ~stall_s;
        core_en  = ~stall_s;
        if (stall_s) begin
            bus.req_ready = '0;
        end else begin
            bus.req_ready = grant_s;
        end
        if (issue_s) begin
            core_din = bus.req_data[int'(win_idx_s)*BF16_W +: BF16_W];
        end else begin
            core_din = 16'h0000;
        end
    end

    // Shift valid/tag in lockstep with the core; count entries on enabled edges
    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        rr_ptr_d    = rr_ptr_q;
        in_flight_d = in_flight_q;
        if (core_en) begin
            valid_d = {valid_q[CORE_LAT-2:0], issue_s};
            tag_d[0] = issue_s ? win_idx_s : '0;
            for (int i = 1; i < CORE_LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
            in_flight_d = in_flight_q + IF_W'(issue_s) - IF_W'(accept_s);
        end else begin
            valid_d = valid_q;
        end
        if (issue_s) begin
            rr_ptr_d = (win_idx_s == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx_s + TAG_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers; the core itself is unreset so stale data is masked by valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            rr_ptr_q    <= '0;
            in_flight_q <= '0;
            for (int i = 0; i < CORE_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rr_ptr_q    <= rr_ptr_d;
            in_flight_q <= in_flight_d;
            for (int i = 0; i < CORE_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign bus.out_valid = valid_q[CORE_LAT-1];
    assign bus.out_tag   = tag_q[CORE_LAT-1];
    assign bus.out_data  = core_dout;
    assign in_flight     = in_flight_q;
    assign busy          = |in_flight_q;

endmodule

// File: tb/tb_tanh_bf16_arbiter.sv
// Bench for tanh_bf16_arbiter: a stand-in 4-stage core plus a tagged result scoreboard.
module tb_tanh_bf16_arbiter;
    import tanh_bf16_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] core_din;
    logic        core_en;
    logic [15:0] core_dout;
    logic [2:0]  in_flight;
    logic        busy;
    logic [15:0] cs [4];
    logic [3:0]  last_ready;

    int tests_run;
    int tests_failed;

    tagged_result_t sbq[$];

    tanh_bf16_arbiter_if #(.NUM_REQ(4), .TAG_W(2)) bus ();

    tanh_bf16_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_din  (core_din),
        .core_en   (core_en),
        .core_dout (core_dout),
        .in_flight (in_flight),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] core_fn(input logic [15:0] x);
        return {x[7:0], x[15:8]} ^ 16'h5A5A;
    endfunction

    // Stand-in for the tanh LUT core: four enabled stages, no reset
    always @(posedge clk) begin
        if (core_en) begin
            cs[0] <= core_fn(core_din);
            cs[1] <= cs[0];
            cs[2] <= cs[1];
            cs[3] <= cs[2];
        end
    end
    assign core_dout = cs[3];

    // One clock: scoreboard work at the falling edge, return just after the rising edge
    task automatic tick();
        tagged_result_t e;
        @(negedge clk);
        if (rst) begin
            sbq.delete();
        end else begin
            tests_run++;
            if ($isunknown(in_flight) || int'(in_flight) != sbq.size() || busy !== (sbq.size() != 0)) begin
                tests_failed++;
                $display("FAIL in_flight: got %0d busy %0b, want %0d", in_flight, busy, sbq.size());
            end
            tests_run++;
            if (!$onehot0(bus.req_ready) || (bus.req_ready & ~bus.req_valid) != 4'b0000) begin
                tests_failed++;
                $display("FAIL grant_legal: ready %b valid %b", bus.req_ready, bus.req_valid);
            end
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                if (sbq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_out: tag %0d data %h, want nothing", bus.out_tag, bus.out_data);
                end else begin
                    e = sbq.pop_front();
                    if (bus.out_tag !== e.tag || bus.out_data !== e.data) begin
                        tests_failed++;
                        $display("FAIL result: got tag %0d data %h, want tag %0d data %h",
                                 bus.out_tag, bus.out_data, e.tag, e.data);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    e.tag  = tag_t'(i);
                    e.data = core_fn(bus.req_data[i*16 +: 16]);
                    sbq.push_back(e);
                end
            end
        end
        last_ready = bus.req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_ready = 4'b0000;
    endtask

    task automatic drain();
        int n;
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 12) begin
            tick();
            n++;
        end
        tests_run++;
        if (sbq.size() != 0 || in_flight !== 3'd0) begin
            tests_failed++;
            $display("FAIL drain: %0d pending, in_flight %0d, want 0", sbq.size(), in_flight);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_data  = 64'h0;
        bus.out_ready = 1'b1;
        last_ready    = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_tag !== 2'd0 || bus.req_ready !== 4'b0000 ||
            in_flight !== 3'd0 || busy !== 1'b0 || core_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: ov %b tag %0d rdy %b inf %0d busy %b en %b, want 0 0 0000 0 0 1",
                     bus.out_valid, bus.out_tag, bus.req_ready, in_flight, busy, core_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        rst_pulse();
        bus.req_valid = 4'b0100;
        bus.req_data[2*16 +: 16] = BF16_ONE;
        #2;
        tests_run++;
        if (bus.req_ready !== 4'b0100 || core_din !== BF16_ONE) begin
            tests_failed++;
            $display("FAIL single_issue: ready %b din %h, want 0100 3f80", bus.req_ready, core_din);
        end
        tick();
        bus.req_valid = 4'b0000;
        for (int n = 1; n <= 4; n++) begin
            #2;
            tests_run++;
            if (bus.out_valid !== (n == 4) || (n == 4 && (bus.out_tag !== 2'd2 ||
                bus.out_data !== core_fn(BF16_ONE)))) begin
                tests_failed++;
                $display("FAIL single_latency: cycle %0d ov %b tag %0d, want ov %0b tag 2",
                         n, bus.out_valid, bus.out_tag, n == 4);
            end
            tick();
        end
        #2;
        tests_run++;
        if (in_flight !== 3'd0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: in_flight %0d ov %b, want 0 0", in_flight, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_round_robin();
        rst_pulse();
        for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'h4000 + 16'(i);
        for (int c = 0; c < 12; c++) begin
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (last_ready[i]) bus.req_data[i*16 +: 16] = bus.req_data[i*16 +: 16] + 16'h0100;
            end
            #2;
            if (c < 8) begin
                tests_run++;
                if (bus.req_ready !== 4'(1 << (c % 4))) begin
                    tests_failed++;
                    $display("FAIL rr_order: cycle %0d ready %b, want %b", c, bus.req_ready, 4'(1 << (c % 4)));
                end
            end
            if (c >= 4) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_tag !== 2'((c - 4) % 4)) begin
                    tests_failed++;
                    $display("FAIL rr_out: cycle %0d ov %b tag %0d, want 1 %0d", c, bus.out_valid, bus.out_tag, (c - 4) % 4);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_stall();
        logic [15:0] held_data;
        logic [1:0]  held_tag;
        rst_pulse();
        held_data = 16'h0;
        held_tag  = 2'd0;
        for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'hC100 + 16'(i * 3);
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c < 9) ? 4'hF : 4'h0;
            bus.out_ready = (c >= 9);
            for (int i = 0; i < 4; i++) begin
                if (last_ready[i]) bus.req_data[i*16 +: 16] = bus.req_data[i*16 +: 16] + 16'h0011;
            end
            #2;
            if (c < 4) begin
                tests_run++;
                if (core_en !== 1'b1 || bus.out_valid !== 1'b0 || bus.req_ready !== 4'(1 << c)) begin
                    tests_failed++;
                    $display("FAIL fill_no_stall: cycle %0d en %b ov %b ready %b", c, core_en, bus.out_valid, bus.req_ready);
                end
            end
            if (c == 4) begin
                held_data = bus.out_data;
                held_tag  = bus.out_tag;
                tests_run++;
                if (bus.out_valid !== 1'b1 || held_tag !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL stall_head: ov %b tag %0d, want 1 0", bus.out_valid, held_tag);
                end
            end
            if (c >= 4 && c <= 8) begin
                tests_run++;
                if (core_en !== 1'b0 || bus.req_ready !== 4'b0000 ||
                    bus.out_data !== held_data || bus.out_tag !== held_tag) begin
                    tests_failed++;
                    $display("FAIL stall_hold: cycle %0d en %b ready %b data %h tag %0d, want 0 0000 %h %0d",
                             c, core_en, bus.req_ready, bus.out_data, bus.out_tag, held_data, held_tag);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        rst_pulse();
        bus.req_data[1*16 +: 16] = 16'h3E00;
        for (int c = 0; c < 4; c++) begin
            bus.req_valid = (c < 3) ? 4'b0010 : 4'b0000;
            if (last_ready[1]) bus.req_data[1*16 +: 16] = bus.req_data[1*16 +: 16] + 16'h0020;
            #2;
            if (c == 3) begin
                tests_run++;
                if (in_flight !== 3'd3 || bus.out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL pre_reset: in_flight %0d ov %b, want 3 0", in_flight, bus.out_valid);
                end
            end
            tick();
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || in_flight !== 3'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: ov %b in_flight %0d busy %b, want 0 0 0", bus.out_valid, in_flight, busy);
        end
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: 16] = 16'hBF80;
        #2;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL post_reset_grant: ready %b, want 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        for (int n = 1; n <= 4; n++) begin
            #2;
            tests_run++;
            if (bus.out_valid !== (n == 4) || (n == 4 && bus.out_tag !== 2'd0)) begin
                tests_failed++;
                $display("FAIL post_reset_latency: cycle %0d ov %b tag %0d, want ov %0b tag 0",
                         n, bus.out_valid, bus.out_tag, n == 4);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_withdraw();
        for (int v = 0; v < 2; v++) begin
            rst_pulse();
            bus.req_data[1*16 +: 16] = 16'h3C00;
            bus.req_data[3*16 +: 16] = 16'hBC00;
            bus.req_valid = 4'b1010;
            #2;
            tests_run++;
            if (bus.req_ready !== 4'b0010) begin
                tests_failed++;
                $display("FAIL withdraw_first: ready %b, want 0010", bus.req_ready);
            end
            tick();
            bus.req_data[1*16 +: 16] = 16'h3D00;
            bus.req_valid = (v == 0) ? 4'b1010 : 4'b0010;
            #2;
            tests_run++;
            if (bus.req_ready !== ((v == 0) ? 4'b1000 : 4'b0010)) begin
                tests_failed++;
                $display("FAIL withdraw_second: variant %0d ready %b", v, bus.req_ready);
            end
            tick();
            drain();
        end
    endtask

    task automatic test_random();
        rst_pulse();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && !last_ready[i]) begin
                    if ($urandom_range(7) == 0) bus.req_valid[i] = 1'b0;
                end else begin
                    bus.req_valid[i] = ($urandom_range(1) == 1);
                    bus.req_data[i*16 +: 16] = 16'($urandom);
                end
            end
            bus.out_ready = ($urandom_range(3) != 0);
            #2;
            tests_run++;
            if (in_flight > 3'd4) begin
                tests_failed++;
                $display("FAIL in_flight_bound: cycle %0d in_flight %0d, want <= 4", cyc, in_flight);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
